// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage: reset PC, word width,
// halt-word value, FSM encoding and the {pc, inst} prefetch entry.
package fetch_unit_pkg;

    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] HALT_WORD    = 32'h0000_0000;
    // Stale-response counter; a few back-to-back redirects against a slow imem can stack up.
    localparam int          DROP_W       = 8;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, downstream redirect and the decode handshake.
// master = fetch unit, slave = the imem/decode environment around it.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic        halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, inst_pc_plus4, halted,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, inst_pc_plus4, halted,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// In-order prefetch FIFO (module fetch_fifo): power-of-2 depth, synchronous flush,
// simultaneous push/pop legal on both full and empty; head is read combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the top masks head fields whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem word reads, buffers returns in fetch_fifo
// and hands {inst, pc, pc+4} to decode. Optional halt-on-zero-word: FETCH_HALT_ON_ZERO_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    fetch_unit_if.master  io_bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [31:0]       r_fetch_pc;
    logic [CW-1:0]     r_inflight;
    logic [DROP_W-1:0] r_drop;
    logic              r_armed;

    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic [CW:0]       w_occupancy;
    logic              w_redirect;
    logic              w_issue;
    logic              w_rsp_live;
    logic              w_rsp_stale;
    logic              w_push;
    logic              w_pop;
    logic              w_halt_push;

    assign w_redirect  = io_bus.redirect_valid;
    assign w_occupancy = {1'b0, w_count} + {1'b0, r_inflight};

    // Capping FIFO entries + outstanding reads at the depth means every return has a slot.
    assign io_bus.imem_req_valid = r_armed && (r_state == ST_RUN) && !w_redirect &&
                                   (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign io_bus.imem_req_addr  = r_fetch_pc;
    assign w_issue = io_bus.imem_req_valid && io_bus.imem_req_ready;

    assign w_rsp_stale = io_bus.imem_rsp_valid && (r_drop != '0);
    assign w_rsp_live  = io_bus.imem_rsp_valid && (r_drop == '0) && (r_state == ST_RUN);
    assign w_push      = w_rsp_live && !w_redirect;
    assign w_pop       = !w_empty && io_bus.inst_ready && !w_redirect;

    // Live reads are contiguous words ending at fetch_pc-4, so the oldest one owns this return.
    assign w_push_entry.pc   = r_fetch_pc - 32'({r_inflight, 2'b00});
    assign w_push_entry.inst = io_bus.imem_rsp_data;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign w_halt_push   = w_push && (io_bus.imem_rsp_data == HALT_WORD);
    assign io_bus.halted = (r_state == ST_HALT) && w_empty;
`else
    assign w_halt_push   = 1'b0;
    assign io_bus.halted = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (w_redirect)       w_state_nxt = ST_RUN;
        else if (w_halt_push) w_state_nxt = ST_HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_redirect) begin
                // Everything outstanding is now stale, minus whatever returns this very cycle.
                r_fetch_pc <= word_align(io_bus.redirect_pc);
                r_inflight <= '0;
                r_drop     <= r_drop + DROP_W'(r_inflight) - DROP_W'(io_bus.imem_rsp_valid);
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_halt_push) begin
                    r_inflight <= '0;
                    r_drop     <= DROP_W'(r_inflight) + DROP_W'(w_issue) - DROP_W'(1);
                end else begin
                    r_inflight <= r_inflight + CW'(w_issue) - CW'(w_rsp_live);
                    r_drop     <= r_drop - DROP_W'(w_rsp_stale);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign io_bus.inst_valid    = !w_empty;
    assign io_bus.inst_data     = w_empty ? '0 : w_head.inst;
    assign io_bus.inst_pc       = w_empty ? '0 : w_head.pc;
    assign io_bus.inst_pc_plus4 = w_empty ? '0 : w_head.pc + 32'd4;

    a_no_push_on_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order imem model with programmable latency, a stream model of the
// expected PC sequence checked every cycle, plus directed literal checks per scenario.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- imem model ----------------
    int          lat = 1;
    logic [31:0] zero_addr = 32'h1;
    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];
    int rcyc = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == zero_addr) return 32'h0;
        return a ^ 32'h5A5A_0001;
    endfunction

    always begin
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready)
            pend.push_back('{addr: bus.imem_req_addr, due: rcyc + lat});
        @(posedge clk);
        #1;
        rcyc++;
        if (!rst_n) begin
            pend.delete();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= rcyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    end

    // ---------------- stream model + compare ----------------
    logic        mon_en = 1'b0;
    logic [31:0] m_exp_pc, m_req_pc;
    logic        m_halted = 1'b0;
    int          cyc = 0, n_req = 0, n_pop = 0;
    int          t_first_req = -1, t_first_inst = -1;
    logic [31:0] rd_req [3];
    int          rd_nreq = 0, rd_ninst = 0;
    logic [31:0] rd_inst_pc = 32'h0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            chk("halted", 32'(bus.halted), 32'(m_halted));
            if (m_halted) begin
                chk("halt_no_req", 32'(bus.imem_req_valid), 32'd0);
                chk("halt_no_inst", 32'(bus.inst_valid), 32'd0);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                chk("req_addr", bus.imem_req_addr, m_req_pc);
                m_req_pc += 32'd4;
                n_req++;
                if (t_first_req < 0) t_first_req = cyc;
                if (rd_nreq < 3) begin
                    rd_req[rd_nreq] = bus.imem_req_addr;
                    rd_nreq++;
                end
            end
            if (bus.inst_valid) begin
                chk("inst_pc", bus.inst_pc, m_exp_pc);
                chk("inst_data", bus.inst_data, mem_word(m_exp_pc));
                chk("inst_pc_plus4", bus.inst_pc_plus4, m_exp_pc + 32'd4);
                if (t_first_inst < 0) t_first_inst = cyc;
                if (rd_ninst == 0) rd_inst_pc = bus.inst_pc;
                rd_ninst++;
            end
            if (bus.redirect_valid) begin
                chk("redirect_no_req", 32'(bus.imem_req_valid), 32'd0);
                m_exp_pc   = bus.redirect_pc & ~32'h3;
                m_req_pc   = m_exp_pc;
                m_halted   = 1'b0;
                rd_nreq    = 0;
                rd_ninst   = 0;
                rd_inst_pc = 32'h0;
                for (int i = 0; i < 3; i++) rd_req[i] = 32'h1;
            end else if (bus.inst_valid && bus.inst_ready) begin
`ifdef FETCH_HALT_ON_ZERO_EN
                if (mem_word(m_exp_pc) == 32'h0) m_halted = 1'b1;
`endif
                n_pop++;
                m_exp_pc += 32'd4;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset(input int l, input logic [31:0] za);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        lat    = l;
        zero_addr = za;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0040_0000);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_inst_pc_plus4", bus.inst_pc_plus4, 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        m_exp_pc = RST_PC;
        m_req_pc = RST_PC;
        m_halted = 1'b0;
        n_req = 0; n_pop = 0;
        t_first_req = -1; t_first_inst = -1;
        rd_nreq = 0; rd_ninst = 0; rd_inst_pc = 32'h0;
        mon_en = 1'b1;
        rst_n  = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
    endtask

    int p0;
    int k;

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;

        // 1: latency 1, decode always ready -> one instruction per cycle after startup
        do_reset(1, 32'h1);
        repeat (10) @(posedge clk);
        p0 = n_pop;
        repeat (20) @(posedge clk);
        chk("t1_one_per_cycle", 32'(n_pop - p0), 32'd20);
        chk("t1_req_to_inst", 32'(t_first_inst - t_first_req), 32'd2);
        chk("t1_first_pc", rd_inst_pc, 32'h0040_0000);

        // 2: decode stalled -> exactly DEPTH requests, head stable, then clean drain
        do_reset(1, 32'h1);
        bus.inst_ready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t2_req_count", 32'(n_req), 32'd4);
        chk("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("t2_head_pc", bus.inst_pc, 32'h0040_0000);
        chk("t2_no_pop", 32'(n_pop), 32'd0);
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b1;
        repeat (20) @(posedge clk);
        chk("t2_drain_pops", 32'(n_pop), 32'd20);

        // 3: latency 3, redirect with two reads outstanding
        do_reset(3, 32'h1);
        k = 0;
        while (n_req < 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t3_two_inflight", 32'(n_req), 32'd2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0103;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        repeat (15) @(posedge clk);
        chk("t3_first_req_after", rd_req[0], 32'h0040_0100);
        chk("t3_first_inst_after", rd_inst_pc, 32'h0040_0100);

        // 4: redirect coincides with a response and a decode pop
        do_reset(1, 32'h1);
        repeat (8) @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0200;
        @(negedge clk);
        chk("t4_rsp_same_cycle", 32'(bus.imem_rsp_valid), 32'd1);
        chk("t4_pop_same_cycle", 32'(bus.inst_valid && bus.inst_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4_fifo_empty_next", 32'(bus.inst_valid), 32'd0);
        repeat (8) @(posedge clk);
        chk("t4_first_inst_after", rd_inst_pc, 32'h0040_0200);

        // 5: address wrap at the top of the 32-bit space
        redirect_to(32'hFFFF_FFF8);
        repeat (10) @(posedge clk);
        chk("t5_req0", rd_req[0], 32'hFFFF_FFF8);
        chk("t5_req1", rd_req[1], 32'hFFFF_FFFC);
        chk("t5_req2", rd_req[2], 32'h0000_0000);
        chk("t5_first_inst", rd_inst_pc, 32'hFFFF_FFF8);

        // 6: zero word at 0040000C
        do_reset(1, 32'h0040_000C);
        repeat (20) @(posedge clk);
        @(negedge clk);
`ifdef FETCH_HALT_ON_ZERO_EN
        chk("t6_halted", 32'(bus.halted), 32'd1);
        chk("t6_req_stopped", 32'(bus.imem_req_valid), 32'd0);
        chk("t6_pops_to_halt", 32'(n_pop), 32'd4);
        @(posedge clk);
        #1;
        zero_addr = 32'h1;
        redirect_to(32'h0040_0000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_resumed_halted", 32'(bus.halted), 32'd0);
        chk("t6_resumed_pc", rd_inst_pc, 32'h0040_0000);
        chk("t6_resumed_flow", 32'(n_pop > 4), 32'd1);
`else
        chk("t6_nop_halted", 32'(bus.halted), 32'd0);
        chk("t6_nop_passed", 32'(n_pop > 4), 32'd1);
        chk("t6_still_fetching", 32'(bus.inst_valid), 32'd1);
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1);
    end

endmodule
